// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared field indices, BCD limits and calendar helpers for rtc_edit_ctrl
package rtc_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_e;

    localparam int NUM_FLD = 9;

    localparam logic [3:0] FLD_DAY   = 4'd0;
    localparam logic [3:0] FLD_MONTH = 4'd1;
    localparam logic [3:0] FLD_YEAR  = 4'd2;
    localparam logic [3:0] FLD_HOUR  = 4'd3;
    localparam logic [3:0] FLD_MIN   = 4'd4;
    localparam logic [3:0] FLD_SEC   = 4'd5;
    localparam logic [3:0] FLD_THOUR = 4'd6;
    localparam logic [3:0] FLD_TMIN  = 4'd7;
    localparam logic [3:0] FLD_TSEC  = 4'd8;

    localparam logic [7:0] MAX_DAY    = 8'h31;
    localparam logic [7:0] MAX_MONTH  = 8'h12;
    localparam logic [7:0] MAX_YEAR   = 8'h99;
    localparam logic [7:0] MAX_HOUR   = 8'h23;
    localparam logic [7:0] MAX_MINSEC = 8'h59;

    // 10 == 2 (mod 4), so the binary year mod 4 is (2*tens + units) mod 4.
    function automatic logic is_leap(input logic [7:0] year_bcd);
        logic [1:0] s;
        s = {year_bcd[4], 1'b0} + year_bcd[1:0];
        return (s == 2'b00);
    endfunction

    function automatic logic [7:0] days_in_month(input logic [7:0] month_bcd, input logic leap);
        logic [7:0] dim;
        case (month_bcd)
            8'h02:                      dim = leap ? 8'h29 : 8'h28;
            8'h04, 8'h06, 8'h09, 8'h11: dim = 8'h30;
            default:                    dim = MAX_DAY;
        endcase
        return dim;
    endfunction

endpackage

// File: rtl/bcd2_wrap_ctr.sv
// rtl/bcd2_wrap_ctr.sv - two-digit BCD up/down counter wrapping between lo and hi
// carry/borrow flag that the counter sits at its limit, so the next step wraps.
module bcd2_wrap_ctr #(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] lo,
    input  logic [7:0] hi,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic [7:0] up_val,
    output logic [7:0] dn_val,
    output logic       carry,
    output logic       borrow
);

    assign carry  = (q >= hi);
    assign borrow = (q <= lo);

    always_comb begin
        up_val = {q[7:4], q[3:0] + 4'd1};
        if (carry) begin
            up_val = lo;
        end else if (q[3:0] == 4'd9) begin
            up_val = {q[7:4] + 4'd1, 4'd0};
        end
        dn_val = {q[7:4], q[3:0] - 4'd1};
        if (borrow) begin
            dn_val = hi;
        end else if (q[3:0] == 4'd0) begin
            dn_val = {q[7:4] - 4'd1, 4'd9};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (inc) begin
            q <= up_val;
        end else if (dec) begin
            q <= dn_val;
        end
    end

endmodule

// File: rtl/rtc_edit_ctrl.sv
// rtl/rtc_edit_ctrl.sv - date/time/countdown registers with 1 Hz prescaler and button edit mode
// Nine BCD field counters; RUN advances them on tick_1hz, EDIT steps the field at dir.
module rtc_edit_ctrl
    import rtc_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 100000000,
    parameter logic [7:0]  YEAR_RST = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_mode,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] fecha_d,
    output logic [3:0] fecha_u,
    output logic [3:0] mes_d,
    output logic [3:0] mes_u,
    output logic [3:0] ano_d,
    output logic [3:0] ano_u,
    output logic [3:0] H_hora_d,
    output logic [3:0] H_hora_u,
    output logic [3:0] H_min_d,
    output logic [3:0] H_min_u,
    output logic [3:0] H_seg_d,
    output logic [3:0] H_seg_u,
    output logic [3:0] T_hora_d,
    output logic [3:0] T_hora_u,
    output logic [3:0] T_min_d,
    output logic [3:0] T_min_u,
    output logic [3:0] T_seg_d,
    output logic [3:0] T_seg_u,
    output logic [3:0] dir,
    output logic       cursor,
    output logic       tick_1hz,
    output logic       timer_done
);

    localparam int unsigned    PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRE_TC = PW'(CLK_HZ - 1);

    state_e                      state_q, state_d;
    logic [3:0]                  dir_d;
    logic [PW-1:0]               pre_q;
    logic                        pre_wrap, leave_edit;
    logic                        run_tick, ed_up, ed_dn, t_nz, t_last, load_day;
    logic [NUM_FLD-1:0]          inc, dec, carry, borrow;
    logic [NUM_FLD-1:0][7:0]     val_q, up_v, dn_v, lo, hi;
    logic [7:0]                  dim_cur, dim_new, mon_new, yr_new;
    logic                        unused_bits;

    assign pre_wrap   = (pre_q == PRE_TC);
    assign leave_edit = (state_q == ST_EDIT) && btn_mode;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q    <= '0;
            tick_1hz <= 1'b0;
        end else if (leave_edit) begin
            pre_q    <= '0;
            tick_1hz <= 1'b0;
        end else begin
            pre_q    <= pre_wrap ? '0 : pre_q + PW'(1);
            tick_1hz <= pre_wrap;
        end
    end

    // Only the highest-priority button acts; a mode press also swallows a pending tick.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir;
        run_tick = 1'b0;
        ed_up    = 1'b0;
        ed_dn    = 1'b0;
        if (state_q == ST_RUN) begin
            if (btn_mode) begin
                state_d = ST_EDIT;
            end else begin
                run_tick = tick_1hz;
            end
        end else if (btn_mode) begin
            state_d = ST_RUN;
        end else if (btn_right) begin
            dir_d = (dir == FLD_TSEC) ? FLD_DAY : dir + 4'd1;
        end else if (btn_left) begin
            dir_d = (dir == FLD_DAY) ? FLD_TSEC : dir - 4'd1;
        end else if (btn_up) begin
            ed_up = 1'b1;
        end else if (btn_down) begin
            ed_dn = 1'b1;
        end
    end

    assign t_nz   = |{val_q[FLD_THOUR], val_q[FLD_TMIN], val_q[FLD_TSEC]};
    assign t_last = (val_q[FLD_THOUR] == 8'h00) && (val_q[FLD_TMIN] == 8'h00) &&
                    (val_q[FLD_TSEC] == 8'h01);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_FLD; i++) begin
            inc[i] = ed_up && (dir == 4'(i));
            dec[i] = ed_dn && (dir == 4'(i));
        end
        if (run_tick) begin
            inc[FLD_SEC]   = 1'b1;
            inc[FLD_MIN]   = carry[FLD_SEC];
            inc[FLD_HOUR]  = carry[FLD_SEC] & carry[FLD_MIN];
            inc[FLD_DAY]   = carry[FLD_SEC] & carry[FLD_MIN] & carry[FLD_HOUR];
            inc[FLD_MONTH] = carry[FLD_SEC] & carry[FLD_MIN] & carry[FLD_HOUR] & carry[FLD_DAY];
            inc[FLD_YEAR]  = carry[FLD_SEC] & carry[FLD_MIN] & carry[FLD_HOUR] & carry[FLD_DAY] &
                             carry[FLD_MONTH];
            dec[FLD_TSEC]  = t_nz;
            dec[FLD_TMIN]  = t_nz & borrow[FLD_TSEC];
            dec[FLD_THOUR] = t_nz & borrow[FLD_TSEC] & borrow[FLD_TMIN];
        end
    end

    assign dim_cur = days_in_month(val_q[FLD_MONTH], is_leap(val_q[FLD_YEAR]));

    always_comb begin
        lo               = '0;
        hi               = {NUM_FLD{MAX_MINSEC}};
        lo[FLD_DAY]      = 8'h01;
        lo[FLD_MONTH]    = 8'h01;
        hi[FLD_DAY]      = dim_cur;
        hi[FLD_MONTH]    = MAX_MONTH;
        hi[FLD_YEAR]     = MAX_YEAR;
        hi[FLD_HOUR]     = MAX_HOUR;
        hi[FLD_THOUR]    = MAX_HOUR;
    end

    // Clamp looks at the month/year the counters are about to take, so it lands on the same edge.
    always_comb begin
        mon_new = val_q[FLD_MONTH];
        yr_new  = val_q[FLD_YEAR];
        if (inc[FLD_MONTH]) begin
            mon_new = up_v[FLD_MONTH];
        end else if (dec[FLD_MONTH]) begin
            mon_new = dn_v[FLD_MONTH];
        end
        if (inc[FLD_YEAR]) begin
            yr_new = up_v[FLD_YEAR];
        end else if (dec[FLD_YEAR]) begin
            yr_new = dn_v[FLD_YEAR];
        end
        dim_new  = days_in_month(mon_new, is_leap(yr_new));
        load_day = (ed_up || ed_dn) && ((dir == FLD_MONTH) || (dir == FLD_YEAR)) &&
                   (val_q[FLD_DAY] > dim_new);
    end

    for (genvar g = 0; g < NUM_FLD; g++) begin : g_fld
        localparam logic [7:0] RV = ((4'(g) == FLD_DAY) || (4'(g) == FLD_MONTH)) ? 8'h01 :
                                    (4'(g) == FLD_YEAR) ? YEAR_RST : 8'h00;
        bcd2_wrap_ctr #(
            .RST_VAL (RV)
        ) u_ctr (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .lo       (lo[g]),
            .hi       (hi[g]),
            .inc      (inc[g]),
            .dec      (dec[g]),
            .load     ((4'(g) == FLD_DAY) && load_day),
            .load_val (dim_new),
            .q        (val_q[g]),
            .up_val   (up_v[g]),
            .dn_val   (dn_v[g]),
            .carry    (carry[g]),
            .borrow   (borrow[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_RUN;
            cursor     <= 1'b0;
            dir        <= FLD_DAY;
            timer_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cursor     <= (state_d == ST_EDIT);
            dir        <= dir_d;
            timer_done <= run_tick && t_last;
        end
    end

    assign {fecha_d, fecha_u}   = val_q[FLD_DAY];
    assign {mes_d, mes_u}       = val_q[FLD_MONTH];
    assign {ano_d, ano_u}       = val_q[FLD_YEAR];
    assign {H_hora_d, H_hora_u} = val_q[FLD_HOUR];
    assign {H_min_d, H_min_u}   = val_q[FLD_MIN];
    assign {H_seg_d, H_seg_u}   = val_q[FLD_SEC];
    assign {T_hora_d, T_hora_u} = val_q[FLD_THOUR];
    assign {T_min_d, T_min_u}   = val_q[FLD_TMIN];
    assign {T_seg_d, T_seg_u}   = val_q[FLD_TSEC];

    assign unused_bits = ^{up_v, dn_v, carry, borrow};

endmodule

// File: tb/tb_rtc_edit_ctrl.sv
// tb/tb_rtc_edit_ctrl.sv - directed self-checking bench for rtc_edit_ctrl
module tb_rtc_edit_ctrl;

    localparam int unsigned CLK_HZ = 10;
    localparam logic [4:0]  B_MODE  = 5'b10000;
    localparam logic [4:0]  B_RIGHT = 5'b01000;
    localparam logic [4:0]  B_LEFT  = 5'b00100;
    localparam logic [4:0]  B_UP    = 5'b00010;
    localparam logic [4:0]  B_DOWN  = 5'b00001;

    typedef struct {
        logic [4:0]  btn;
        logic [3:0]  dir;
        logic        cursor;
        logic [23:0] date;
        logic [7:0]  hour;
    } vec_t;

    logic clk;
    logic rst_ni;
    logic btn_mode, btn_right, btn_left, btn_up, btn_down;
    logic [3:0] fecha_d, fecha_u, mes_d, mes_u, ano_d, ano_u;
    logic [3:0] H_hora_d, H_hora_u, H_min_d, H_min_u, H_seg_d, H_seg_u;
    logic [3:0] T_hora_d, T_hora_u, T_min_d, T_min_u, T_seg_d, T_seg_u;
    logic [3:0] dir;
    logic       cursor, tick_1hz, timer_done;

    logic [23:0] date_w, time_w, tmr_w;
    logic [7:0]  hour_w;

    int   checks   = 0;
    int   errors   = 0;
    int   tick_cnt = 0;
    int   done_cnt = 0;
    vec_t tbl [17];

    assign date_w = {fecha_d, fecha_u, mes_d, mes_u, ano_d, ano_u};
    assign time_w = {H_hora_d, H_hora_u, H_min_d, H_min_u, H_seg_d, H_seg_u};
    assign tmr_w  = {T_hora_d, T_hora_u, T_min_d, T_min_u, T_seg_d, T_seg_u};
    assign hour_w = {H_hora_d, H_hora_u};

    rtc_edit_ctrl #(
        .CLK_HZ   (CLK_HZ),
        .YEAR_RST (8'h00)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .btn_mode   (btn_mode),
        .btn_right  (btn_right),
        .btn_left   (btn_left),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .fecha_d    (fecha_d),
        .fecha_u    (fecha_u),
        .mes_d      (mes_d),
        .mes_u      (mes_u),
        .ano_d      (ano_d),
        .ano_u      (ano_u),
        .H_hora_d   (H_hora_d),
        .H_hora_u   (H_hora_u),
        .H_min_d    (H_min_d),
        .H_min_u    (H_min_u),
        .H_seg_d    (H_seg_d),
        .H_seg_u    (H_seg_u),
        .T_hora_d   (T_hora_d),
        .T_hora_u   (T_hora_u),
        .T_min_d    (T_min_d),
        .T_min_u    (T_min_u),
        .T_seg_d    (T_seg_d),
        .T_seg_u    (T_seg_u),
        .dir        (dir),
        .cursor     (cursor),
        .tick_1hz   (tick_1hz),
        .timer_done (timer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        {btn_mode, btn_right, btn_left, btn_up, btn_down} = 5'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Called at a negedge: holds the buttons for one rising edge, returns at the next negedge.
    task automatic press(input logic [4:0] b);
        {btn_mode, btn_right, btn_left, btn_up, btn_down} = b;
        @(negedge clk);
        {btn_mode, btn_right, btn_left, btn_up, btn_down} = 5'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_cnt += int'(tick_1hz);
            done_cnt += int'(timer_done);
        end
    endtask

    initial begin
        tbl[0]  = '{B_MODE,           4'd0, 1'b1, 24'h010100, 8'h00};
        tbl[1]  = '{B_DOWN,           4'd0, 1'b1, 24'h310100, 8'h00};
        tbl[2]  = '{B_UP,             4'd0, 1'b1, 24'h010100, 8'h00};
        tbl[3]  = '{B_LEFT,           4'd8, 1'b1, 24'h010100, 8'h00};
        tbl[4]  = '{B_RIGHT,          4'd0, 1'b1, 24'h010100, 8'h00};
        tbl[5]  = '{B_RIGHT,          4'd1, 1'b1, 24'h010100, 8'h00};
        tbl[6]  = '{B_DOWN,           4'd1, 1'b1, 24'h011200, 8'h00};
        tbl[7]  = '{B_UP,             4'd1, 1'b1, 24'h010100, 8'h00};
        tbl[8]  = '{B_RIGHT,          4'd2, 1'b1, 24'h010100, 8'h00};
        tbl[9]  = '{B_DOWN,           4'd2, 1'b1, 24'h010199, 8'h00};
        tbl[10] = '{B_UP | B_DOWN,    4'd2, 1'b1, 24'h010100, 8'h00};
        tbl[11] = '{B_RIGHT | B_LEFT, 4'd3, 1'b1, 24'h010100, 8'h00};
        tbl[12] = '{B_DOWN,           4'd3, 1'b1, 24'h010100, 8'h23};
        tbl[13] = '{B_LEFT | B_UP,    4'd2, 1'b1, 24'h010100, 8'h23};
        tbl[14] = '{B_MODE | B_RIGHT, 4'd2, 1'b0, 24'h010100, 8'h23};
        tbl[15] = '{B_UP,             4'd2, 1'b0, 24'h010100, 8'h23};
        tbl[16] = '{B_MODE,           4'd2, 1'b1, 24'h010100, 8'h23};

        do_reset();
        @(negedge clk);
        check("rst_date", date_w, 24'h010100);
        check("rst_time", time_w, 24'h000000);
        check("rst_timer", tmr_w, 24'h000000);
        check("rst_ctl", {dir, cursor, tick_1hz, timer_done}, {4'd0, 3'b000});

        for (int i = 0; i < 17; i++) begin
            press(tbl[i].btn);
            check($sformatf("vec%0d", i), {dir, cursor, date_w, hour_w},
                  {tbl[i].dir, tbl[i].cursor, tbl[i].date, tbl[i].hour});
        end

        // Full rollover 23:59:59 31/12/99 -> 00:00:00 01/01/00
        do_reset();
        press(B_MODE);
        press(B_DOWN);
        repeat (5) begin
            press(B_RIGHT);
            press(B_DOWN);
        end
        check("t1_set", {date_w, time_w}, {24'h311299, 24'h235959});
        press(B_MODE);
        tick_cnt = 0;
        run(10);
        check("t1_tick_seen", tick_cnt, 1);
        check("t1_before_upd", time_w, 24'h235959);
        run(1);
        check("t1_time", time_w, 24'h000000);
        check("t1_date", date_w, 24'h010100);
        check("t1_tick_once", tick_cnt, 1);

        // Countdown from 00:00:02
        do_reset();
        press(B_MODE);
        press(B_LEFT);
        repeat (2) press(B_UP);
        press(B_MODE);
        tick_cnt = 0;
        done_cnt = 0;
        run(11);
        check("t2_timer1", tmr_w, 24'h000001);
        check("t2_no_done_yet", done_cnt, 0);
        run(10);
        check("t2_timer0", tmr_w, 24'h000000);
        check("t2_done_now", timer_done, 1'b1);
        run(25);
        check("t2_done_once", done_cnt, 1);
        check("t2_timer_held", tmr_w, 24'h000000);
        check("t2_clock_runs", time_w, 24'h000004);

        // Leap day then clamp on year edit
        do_reset();
        press(B_MODE);
        repeat (27) press(B_UP);
        press(B_RIGHT);
        press(B_UP);
        press(B_RIGHT);
        repeat (24) press(B_UP);
        repeat (3) begin
            press(B_RIGHT);
            press(B_DOWN);
        end
        check("t3_set", {date_w, time_w}, {24'h280224, 24'h235959});
        press(B_MODE);
        run(11);
        check("t3_leap_day", {date_w, time_w}, {24'h290224, 24'h000000});
        press(B_MODE);
        check("t3_dir_kept", {dir, cursor}, {4'd5, 1'b1});
        repeat (3) press(B_LEFT);
        press(B_UP);
        check("t3_clamp", date_w, 24'h280225);

        // dir wrap and day wrap in a 30-day month
        do_reset();
        press(B_MODE);
        press(B_LEFT);
        check("t4_dir_left_wrap", dir, 4'd8);
        press(B_RIGHT);
        check("t4_dir_right_wrap", dir, 4'd0);
        press(B_RIGHT);
        repeat (3) press(B_UP);
        press(B_LEFT);
        press(B_DOWN);
        check("t4_day_wrap_30", date_w, 24'h300400);

        // Coincident buttons and mode-with-tick
        do_reset();
        press(B_MODE);
        repeat (3) press(B_RIGHT);
        press(B_RIGHT | B_UP);
        check("t5_right_over_up", {dir, time_w}, {4'd4, 24'h000000});
        press(B_RIGHT);
        repeat (10) press(B_UP);
        press(B_MODE);
        tick_cnt = 0;
        run(10);
        check("t5_tick_now", {tick_1hz, time_w}, {1'b1, 24'h000010});
        press(B_MODE);
        check("t5_mode_drops_tick", {cursor, time_w}, {1'b1, 24'h000010});
        run(15);
        check("t5_frozen", time_w, 24'h000010);
        check("t5_prescaler_in_edit", tick_cnt, 2);

        // Asynchronous reset mid-edit
        do_reset();
        press(B_MODE);
        repeat (5) press(B_RIGHT);
        repeat (42) press(B_UP);
        check("t6_pre", {dir, cursor, time_w}, {4'd5, 1'b1, 24'h000042});
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_async_ctl", {dir, cursor}, {4'd0, 1'b0});
        check("t6_async_vals", {date_w, time_w, tmr_w}, {24'h010100, 24'h000000, 24'h000000});
        @(negedge clk);
        rst_ni = 1'b1;
        press(B_MODE);
        check("t6_after_release", {dir, cursor, time_w}, {4'd0, 1'b1, 24'h000000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
